uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter: serializes a parallel word into a start/data/parity/stop frame on TX_OUT.
- Runs on the same oversampled CLK and Prescale as the receive path, so no separate baud clock is needed.
- Internal prescale counter holds each bit for exactly Prescale CLK cycles.
- Sits in the UART top, mirroring the RX chain, fed by the system-side register/FIFO logic.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB first

Ports:
CLK  input  1  system/oversampling clock, rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_Valid  input  1  request to send P_DATA; single-cycle or held
PAR_EN  input  1  1 = insert parity bit after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  5  CLK cycles per bit; legal 8 or 16, any value 4..31 works
TX_OUT  output  1  serial line, idles high
Busy  output  1  high while a frame is in progress

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset (async, any time incl. mid-frame): state IDLE, TX_OUT=1, Busy=0, counters and holding registers cleared. Line returns high immediately, with no partial-bit completion.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - On a rising edge with Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and Prescale (Prescale<4 is latched as 4).
  - Parity bit = XOR(P_DATA) XOR PAR_TYP.
  - Go to START. TX_OUT=0 and Busy=1 appear after that same edge (1-cycle latency from Data_Valid to start bit).
- Bit timing: a counter runs 0..Prescale_latched-1. A bit ends when the counter equals Prescale_latched-1; the counter then wraps to 0 and the FSM advances.
- START: TX_OUT=0 for Prescale cycles, then DATA.
- DATA:
  - TX_OUT = data[bit_idx], with bit_idx running 0..DATA_WIDTH-1, each bit held Prescale cycles.
  - After bit DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = latched parity bit for Prescale cycles, then STOP.
- STOP:
  - TX_OUT=1 for Prescale cycles, then IDLE.
  - Busy falls on the same edge the FSM enters IDLE.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1) × Prescale cycles of Busy=1.
- Back-to-back frames: Data_Valid is only sampled in IDLE. The earliest next start bit is driven one cycle after entering IDLE, so the minimum gap between frames is one stop bit plus 1 CLK.
- Data_Valid while Busy=1 is ignored; the request is not queued.
- Changes to P_DATA, PAR_EN, PAR_TYP or Prescale mid-frame have no effect on the current frame.
- Data_Valid held high continuously produces back-to-back frames, each separated by exactly 1 idle CLK.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 × Prescale cycles (two stop bits). Frame length grows by one bit time; Busy extends accordingly.
- Undefined: single stop bit as described above.

Test Plan:
- Prescale=8, PAR_EN=0, P_DATA=0xA5, Data_Valid 1-cycle pulse -> TX_OUT bits 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; Busy high exactly 80 cycles; TX_OUT=1 afterwards.
- Prescale=16, PAR_EN=1, PAR_TYP=0, P_DATA=0x07 -> parity bit 1, frame 11 bits, Busy high 176 cycles. Repeat with PAR_TYP=1 -> parity bit 0.
- Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 -> parity bit 0. Change P_DATA to 0xFF and Prescale to 16 at cycle 20 -> frame unchanged.
- Second Data_Valid with P_DATA=0x3C pulsed at cycle 30 of a frame -> ignored, exactly one frame sent. Data_Valid held high with 0x55 -> consecutive frames with exactly 1 CLK of TX_OUT=1 between stop bit and next start bit.
- Assert RST low during data bit 3 -> TX_OUT=1 and Busy=0 immediately. After release, Data_Valid with 0x81 -> clean full frame.
- With UART_TX_TWO_STOP_EN defined, Prescale=8, PAR_EN=0 -> stop high 16 cycles, Busy high 88 cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start/data/optional parity/stop framing, each bit held Prescale CLK cycles.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic [4:0]            cnt_q;
  logic [4:0]            presc_q;
  logic [4:0]            presc_d;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_bit_d;
  logic                  tx_q;
  logic                  busy_q;
  logic                  bit_end;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q;
`endif

  // Bit periods shorter than 4 cycles are stretched to 4.
  assign presc_d   = (Prescale < 5'd4) ? 5'd4 : Prescale;
  assign par_bit_d = (^P_DATA) ^ PAR_TYP;
  assign bit_end   = (cnt_q == presc_q - 5'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      presc_q   <= 5'd4;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      if (state_q != IDLE) begin
        cnt_q <= bit_end ? 5'd0 : cnt_q + 5'd1;
      end
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          idx_q  <= '0;
          if (Data_Valid) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit_d;
            presc_q   <= presc_d;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= data_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= data_q[idx_q + 1'b1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
            if (!stop2_q) begin
              stop2_q <= 1'b1;
            end else begin
              stop2_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
`else
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed and random frames compared cycle by cycle with a bit-list model.
module tb_uart_tx_frame;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [4:0]   Prescale;
  logic         TX_OUT;
  logic         Busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request just before a rising edge; a pulse is dropped right after it.
  task automatic start(input logic [W-1:0] d, input logic pe, input logic pt,
                       input int pr, input bit hold);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = 5'(pr);
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) Data_Valid = 1'b0;
  endtask

  // Reference: the frame is a list of bit values, each lasting the effective prescale.
  // kind 1 changes the inputs at cycle dk; kind 2 pulses a second request at cycle dk.
  task automatic expect_frame(input string name, input logic [W-1:0] d, input logic pe,
                              input logic pt, input int pr, input int dk, input int kind);
    int   p;
    int   cyc;
    int   busy_cnt;
    logic bits[$];
    p        = (pr < 4) ? 4 : pr;
    cyc      = 0;
    busy_cnt = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
    bits.push_back(1'b1);
`endif
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge CLK);
        chk({name, "_tx"}, 32'(TX_OUT), 32'(bits[b]));
        if (c == p / 2) chk({name, "_busy"}, 32'(Busy), 32'd1);
        if (Busy === 1'b1) busy_cnt++;
        if (kind == 1 && cyc == dk) begin
          P_DATA   = 8'hFF;
          Prescale = 5'd16;
          PAR_TYP  = ~PAR_TYP;
        end
        if (kind == 2 && cyc == dk) begin
          P_DATA     = 8'h3C;
          Data_Valid = 1'b1;
        end
        if (kind == 2 && cyc == dk + 1) Data_Valid = 1'b0;
        cyc++;
      end
    end
    @(negedge CLK);
    chk({name, "_idle_tx"}, 32'(TX_OUT), 32'd1);
    chk({name, "_idle_busy"}, 32'(Busy), 32'd0);
    chk({name, "_busy_len"}, 32'(busy_cnt), 32'(bits.size() * p));
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rpe;
    logic         rpt;
    int           rpr;

    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 5'd8;
    #12;
    chk("reset_tx", 32'(TX_OUT), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_tx", 32'(TX_OUT), 32'd1);

    start(8'hA5, 1'b0, 1'b0, 8, 1'b0);
    expect_frame("a5_p8", 8'hA5, 1'b0, 1'b0, 8, -1, 0);

    start(8'h07, 1'b1, 1'b0, 16, 1'b0);
    expect_frame("07_even", 8'h07, 1'b1, 1'b0, 16, -1, 0);
    start(8'h07, 1'b1, 1'b1, 16, 1'b0);
    expect_frame("07_odd", 8'h07, 1'b1, 1'b1, 16, -1, 0);

    start(8'hA5, 1'b1, 1'b0, 8, 1'b0);
    expect_frame("midchg", 8'hA5, 1'b1, 1'b0, 8, 20, 1);

    start(8'h11, 1'b0, 1'b0, 8, 1'b0);
    expect_frame("ignore_dv", 8'h11, 1'b0, 1'b0, 8, 30, 2);
    repeat (3) @(negedge CLK);
    chk("ignore_dv_no_frame", 32'(Busy), 32'd0);

    start(8'h55, 1'b0, 1'b0, 8, 1'b1);
    expect_frame("held1", 8'h55, 1'b0, 1'b0, 8, -1, 0);
    expect_frame("held2", 8'h55, 1'b0, 1'b0, 8, -1, 0);
    Data_Valid = 1'b0;
    @(negedge CLK);
    chk("held_stop_busy", 32'(Busy), 32'd0);

    start(8'h02, 1'b0, 1'b0, 2, 1'b0);
    expect_frame("clamp4", 8'h02, 1'b0, 1'b0, 2, -1, 0);

    start(8'hC6, 1'b0, 1'b0, 8, 1'b0);
    repeat (8 * 4 + 3) @(negedge CLK);
    chk("pre_rst_bit3", 32'(TX_OUT), 32'd0);
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(TX_OUT), 32'd1);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_busy", 32'(Busy), 32'd0);
    start(8'h81, 1'b0, 1'b0, 8, 1'b0);
    expect_frame("after_rst", 8'h81, 1'b0, 1'b0, 8, -1, 0);

    for (int k = 0; k < 8; k++) begin
      rd  = W'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      rpr = int'($urandom_range(0, 31));
      start(rd, rpe, rpt, rpr, 1'b0);
      expect_frame("rand", rd, rpe, rpt, rpr, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
